// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type, legal block widths and
// ShiftRows index helpers used by the permutation network.
package aes_pkg;

  typedef logic [7:0] aes_byte_t;

  localparam int NB_4 = 4;
  localparam int NB_6 = 6;
  localparam int NB_8 = 8;

  function automatic bit nb_legal(input int nb);
    return (nb == NB_4) || (nb == NB_6) || (nb == NB_8);
  endfunction

  // 256-bit blocks move rows 2 and 3 one column further
  function automatic int row_shift(input int nb, input int r);
    if (nb == NB_8 && r >= 2)
      return r + 1;
    return r;
  endfunction

  function automatic int byte_idx(input int c, input int r);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/shift_rows_stage_if.sv
// Handshake bundle for shift_rows_stage: upstream state/tag channel
// and downstream permuted-state channel.
interface shift_rows_stage_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [32*NB-1:0]  in_state;
  logic              in_inv;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [32*NB-1:0]  out_state;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_state, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_state, out_tag
  );

  modport slave (
    input  in_valid, in_state, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_state, out_tag
  );
endinterface

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation.
// Inverse network only built with SHIFT_ROWS_STAGE_INV_EN.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] state_i,
  input  logic             inv_i,
  output logic [32*NB-1:0] state_o
);
  localparam int IW = $clog2(NB) + 1;

  logic [32*NB-1:0] fwd;
`ifdef SHIFT_ROWS_STAGE_INV_EN
  logic [32*NB-1:0] bwd;
`endif

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int S = row_shift(NB, r);
      localparam logic [IW-1:0] FC = IW'((c + S) % NB);
      assign fwd[8*byte_idx(c, r) +: 8] =
        state_i[8*byte_idx(int'(FC), r) +: 8];
`ifdef SHIFT_ROWS_STAGE_INV_EN
      localparam logic [IW-1:0] IC = IW'((c - S + NB) % NB);
      assign bwd[8*byte_idx(c, r) +: 8] =
        state_i[8*byte_idx(int'(IC), r) +: 8];
`endif
    end
  end

`ifdef SHIFT_ROWS_STAGE_INV_EN
  assign state_o = inv_i ? bwd : fwd;
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign state_o    = fwd;
`endif

endmodule

// File: rtl/shift_rows_stage.sv
// Registered ShiftRows pipeline stage with valid/ready handshake.
// Inverse direction available when SHIFT_ROWS_STAGE_INV_EN is defined.
module shift_rows_stage
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  shift_rows_stage_if.slave bus
);
  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_stage: NB must be 4, 6 or 8");
  end

  logic [32*NB-1:0] perm;
  logic             accept;
  logic             valid_q, valid_d;
  logic [32*NB-1:0] state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  shift_rows_perm #(
    .NB (NB)
  ) u_perm (
    .state_i (bus.in_state),
    .inv_i   (bus.in_inv),
    .state_o (perm)
  );

  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_state = state_q;
  assign bus.out_tag   = tag_q;

  always_comb begin
    valid_d = valid_q;
    state_d = state_q;
    tag_d   = tag_q;
    if (accept) begin
      valid_d = 1'b1;
      state_d = perm;
      tag_d   = bus.in_tag;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      state_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_shift_rows_stage.sv
// Directed self-checking bench for shift_rows_stage (NB = 4, 6, 8).
module tb_shift_rows_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  shift_rows_stage_if #(.NB(4), .TAG_W(4)) b4 ();
  shift_rows_stage_if #(.NB(6), .TAG_W(4)) b6 ();
  shift_rows_stage_if #(.NB(8), .TAG_W(4)) b8 ();

  shift_rows_stage #(.NB(4), .TAG_W(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  shift_rows_stage #(.NB(6), .TAG_W(4)) u6 (.clk(clk), .rst(rst), .bus(b6));
  shift_rows_stage #(.NB(8), .TAG_W(4)) u8 (.clk(clk), .rst(rst), .bus(b8));

  localparam logic [127:0] IDX4 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] FWD4 = 128'h0b06010c_07020d08_030e0904_0f0a0500;
  localparam logic [127:0] INV4 = 128'h0306090c_0f020508_0b0e0104_070a0d00;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [127:0] m4(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
      end
    return o;
  endfunction

  initial begin
    logic [191:0] idx6;
    logic [255:0] idx8;
    logic [127:0] s0, r1, held;
    logic [127:0] bpd [8];
    logic [3:0]   pat;
    logic         mvalid, stall, acc;
    int           sent, recv;

    for (int k = 0; k < 24; k++) idx6[8*k +: 8] = 8'(k);
    for (int k = 0; k < 32; k++) idx8[8*k +: 8] = 8'(k);
    for (int k = 0; k < 8; k++)
      bpd[k] = {$urandom, $urandom, $urandom, $urandom};
    pat = 4'b1001;

    b4.in_valid = 0; b4.in_state = '0; b4.in_inv = 0; b4.in_tag = '0;
    b4.out_ready = 1;
    b6.in_valid = 0; b6.in_state = '0; b6.in_inv = 0; b6.in_tag = '0;
    b6.out_ready = 1;
    b8.in_valid = 0; b8.in_state = '0; b8.in_inv = 0; b8.in_tag = '0;
    b8.out_ready = 1;

    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(b4.out_valid), 128'(1'b0));
    chk("rst_state", b4.out_state, 128'(0));
    chk("rst_tag", 128'(b4.out_tag), 128'(0));
    rst = 0;
    @(negedge clk);
    chk("rst_ready", 128'(b4.in_ready), 128'(1'b1));

    b4.in_valid = 1; b4.in_state = IDX4; b4.in_inv = 0; b4.in_tag = 4'h5;
    b6.in_valid = 1; b6.in_state = idx6; b6.in_tag = 4'h6;
    b8.in_valid = 1; b8.in_state = idx8; b8.in_tag = 4'h8;
    #1 chk("fwd4_lat0", 128'(b4.out_valid), 128'(1'b0));
    @(negedge clk);
    b4.in_valid = 0; b6.in_valid = 0; b8.in_valid = 0;
    chk("fwd4_valid", 128'(b4.out_valid), 128'(1'b1));
    chk("fwd4_state", b4.out_state, FWD4);
    chk("fwd4_col0", 128'(b4.out_state[31:0]), 128'(32'h0f0a0500));
    chk("fwd4_col3", 128'(b4.out_state[127:96]), 128'(32'h0b06010c));
    chk("fwd4_tag", 128'(b4.out_tag), 128'(4'h5));
    chk("fwd8_col0", 128'(b8.out_state[31:0]), 128'(32'h130e0500));
    chk("fwd8_col7", 128'(b8.out_state[255:224]), 128'(32'h0f0a011c));
    chk("fwd8_tag", 128'(b8.out_tag), 128'(4'h8));
    chk("fwd6_col0", 128'(b6.out_state[31:0]), 128'(32'h0f0a0500));
    chk("fwd6_col5", 128'(b6.out_state[191:160]), 128'(32'h0b060114));

    b4.in_valid = 1; b4.in_state = IDX4; b4.in_inv = 1; b4.in_tag = 4'ha;
    @(negedge clk);
    b4.in_valid = 0;
`ifdef SHIFT_ROWS_STAGE_INV_EN
    chk("inv4_state", b4.out_state, INV4);
    chk("inv4_col0", 128'(b4.out_state[31:0]), 128'(32'h070a0d00));
`else
    chk("inv4_state", b4.out_state, FWD4);
`endif
    chk("inv4_tag", 128'(b4.out_tag), 128'(4'ha));

    s0 = {$urandom, $urandom, $urandom, $urandom};
    b4.in_valid = 1; b4.in_state = s0; b4.in_inv = 0; b4.in_tag = 4'h3;
    @(negedge clk);
    r1 = b4.out_state;
    chk("rt_pass1", r1, m4(s0, 1'b0));
    chk("rt_tag1", 128'(b4.out_tag), 128'(4'h3));
    b4.in_state = r1; b4.in_inv = 1;
    @(negedge clk);
    b4.in_valid = 0; b4.in_inv = 0;
`ifdef SHIFT_ROWS_STAGE_INV_EN
    chk("rt_pass2", b4.out_state, s0);
`else
    chk("rt_pass2", b4.out_state, m4(r1, 1'b0));
`endif
    chk("rt_tag2", 128'(b4.out_tag), 128'(4'h3));
    @(negedge clk);
    chk("rt_drain", 128'(b4.out_valid), 128'(1'b0));

    mvalid = 0; stall = 0; sent = 0; recv = 0; held = '0;
    for (int k = 0; k < 40 && recv < 8; k++) begin
      if (stall) chk("bp_hold", b4.out_state, held);
      chk("bp_valid", 128'(b4.out_valid), 128'(mvalid));
      b4.out_ready = pat[k%4];
      b4.in_valid  = sent < 8;
      b4.in_state  = bpd[sent%8];
      b4.in_tag    = sent[3:0];
      b4.in_inv    = 0;
      #1;
      chk("bp_ready", 128'(b4.in_ready), 128'(!mvalid || b4.out_ready));
      if (mvalid && b4.out_ready) begin
        chk("bp_data", b4.out_state, m4(bpd[recv%8], 1'b0));
        chk("bp_tag", 128'(b4.out_tag), 128'(recv[3:0]));
        recv++;
      end
      acc    = b4.in_valid && (!mvalid || b4.out_ready);
      stall  = mvalid && !b4.out_ready;
      held   = b4.out_state;
      mvalid = acc || stall;
      if (acc) sent++;
      @(negedge clk);
    end
    b4.in_valid = 0; b4.out_ready = 1;
    chk("bp_count", 128'(recv), 128'(8));
    chk("bp_sent", 128'(sent), 128'(8));
    chk("bp_nodup", 128'(b4.out_valid), 128'(1'b0));

    b4.out_ready = 0;
    b4.in_valid = 1; b4.in_state = IDX4; b4.in_tag = 4'h7;
    @(negedge clk);
    b4.in_valid = 0;
    chk("mr_held", 128'(b4.out_valid), 128'(1'b1));
    rst = 1;
    b4.in_valid = 1; b4.in_state = s0; b4.in_tag = 4'he;
    @(negedge clk);
    rst = 0; b4.in_valid = 0;
    chk("mr_valid", 128'(b4.out_valid), 128'(1'b0));
    chk("mr_state", b4.out_state, 128'(0));
    chk("mr_tag", 128'(b4.out_tag), 128'(0));
    chk("mr_ready", 128'(b4.in_ready), 128'(1'b1));
    b4.out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mr_gone", 128'(b4.out_valid), 128'(1'b0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_rows_stage.md
# shift_rows_stage

Registered, parametrised AES/Rijndael ShiftRows unit with a valid/ready handshake. It supports block widths of NB = 4, 6 or 8 columns, and forward or inverse shifting selected per transaction. It sits between SubBytes and MixColumns in the pipelined cipher datapath. It replaces the purely combinational 4-column forward-only permutation with a single pipeline stage that carries a sideband tag.

## Interface
Parameters:
- NB, 4, number of state columns (legal: 4, 6, 8; any other value is a compile-time error)
- TAG_W, 4, width of opaque sideband tag carried alongside the state

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  stage can accept input this cycle
- in_state  in  32*NB  state; byte (c,r) at bits [8*(4c+r)+7 : 8*(4c+r)], c = column, r = row 0..3
- in_inv  in  1  0 = forward ShiftRows, 1 = InvShiftRows
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output transaction present
- out_ready  in  1  downstream accepts output
- out_state  out  32*NB  permuted state, same byte layout as in_state
- out_tag  out  TAG_W  tag of the transaction on out_state

## Operation
- Row offsets s(r):
  - NB = 4 or 6: {0, 1, 2, 3}
  - NB = 8: {0, 1, 3, 4}
- Forward: out(c,r) = in((c + s(r)) mod NB, r).
- Inverse: out(c,r) = in((c − s(r) + NB) mod NB, r).
- All column-index arithmetic is done modulo NB on indices of width clog2(NB)+1. Row 0 is never moved.
- Accept condition: in_valid && in_ready.
- Output register loads the permuted state and tag on accept.
- out_valid:
  - set on accept;
  - cleared on out_valid && out_ready with no simultaneous accept;
  - stays 1 when a drain and an accept occur in the same cycle (back-to-back).
- in_ready = !out_valid || out_ready. This is combinational from out_ready; it is the only comb path from an output to an input.
- While out_valid && !out_ready, out_state and out_tag are held stable.
- in_inv is sampled only on accept. It has no effect otherwise.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 transaction/cycle when out_ready stays high.
- Reset (rst = 1 at a clock edge):
  - out_valid = 0, out_state = 0, out_tag = 0;
  - any held transaction is discarded;
  - in_ready reads 1 in the cycle after reset is released;
  - an input offered in the same cycle as rst is dropped.
- out_ready may toggle freely. Data is never lost or duplicated.
- in_valid may be withdrawn without being accepted. No sticky state results.

## Configuration
- SHIFT_ROWS_STAGE_INV_EN defined:
  - inverse path is compiled in;
  - in_inv selects the direction as above.
- Not defined:
  - only the forward permutation is built;
  - the in_inv port still exists but is ignored (treated as 0);
  - area is one permutation network instead of two plus a mux.

## Structure
- Shared package aes_pkg:
  - legal-NB constants;
  - function row_shift(NB, r) returning s(r);
  - function byte_idx(c, r) returning 4c+r;
  - AES byte typedef (8-bit).
- Sub-module shift_rows_perm:
  - purely combinational;
  - parameter NB, inputs state and inv, output permuted state;
  - instantiated once.
- The top level holds only the handshake and the output register.

## Test plan
- NB=4, forward, in byte(c,r) = 4c+r:
  - out column 0 = {0, 5, 10, 15};
  - out column 3 = {12, 1, 6, 11};
  - out_valid one cycle after accept.
- NB=4, inverse, same input → out column 0 = {0, 13, 10, 7}.
- NB=8, forward, byte(c,r) = 4c+r → out column 0 = {0, 5, 14, 19}; NB=6 forward column 5 = {20, 1, 6, 11}.
- Round trip: random state forward then fed back inverse → identical to original; tag preserved on both passes.
- Backpressure:
  - stream 8 transactions with out_ready toggling 1,0,0,1,…;
  - out_state stable while stalled;
  - in_ready = 0 whenever out_valid && !out_ready;
  - all 8 emerge in order, none lost or duplicated.
- Reset mid-stream: assert rst while out_valid = 1 and out_ready = 0 → next cycle out_valid = 0, out_state = 0, out_tag = 0, in_ready = 1; held transaction never appears.
